// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO: edge-detected push, show-ahead pop, level irq
// Optional idle timeout is built when UART_RX_FIFO_TIMEOUT_EN is defined.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2    = 4,
  parameter int TIMEOUT_TICKS = 40
) (
  input  logic                  clk,
  input  logic                  RSTn,
  input  logic [7:0]            rx_data,
  input  logic                  rx_done,
  input  logic                  baud_tick,
  input  logic                  rd_en,
  input  logic                  clr_ovr,
  input  logic [DEPTH_LOG2:0]   thresh,
  output logic [7:0]            rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overrun,
  output logic                  timeout,
  output logic                  irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [7:0]    mem_q [DEPTH];
  logic          rx_done_q, rx_done_d;
  logic          inhibit_q, inhibit_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          overrun_q, overrun_d;
  logic          irq_q, irq_d;
  logic          push, pop, drop, wr;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  always_comb begin
    push      = rx_done & ~rx_done_q & ~inhibit_q;
    pop       = rd_en & ~empty;
    drop      = push & full & ~pop;
    wr        = push & ~drop;
    rx_done_d = rx_done;
    inhibit_d = 1'b0;
    wr_ptr_d  = wr  ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d   = count_q;
    case ({wr, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // The new head may be the slot being written this cycle, so bypass rx_data.
    rd_data_d = rd_data_q;
    if (wr | pop) begin
      if (wr && (wr_ptr_q == rd_ptr_d)) rd_data_d = rx_data;
      else                              rd_data_d = mem_q[rd_ptr_d];
    end
    overrun_d = drop | (overrun_q & ~clr_ovr);
    irq_d     = ((thresh != '0) & (count_q >= thresh)) | overrun_q | timeout;
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      rx_done_q <= 1'b0;
      inhibit_q <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= 8'h00;
      overrun_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      rx_done_q <= rx_done_d;
      inhibit_q <= inhibit_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
      overrun_q <= overrun_d;
      irq_q     <= irq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= rx_data;
  end

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  logic [TW-1:0] idle_q, idle_d;
  logic          timeout_q, timeout_d;

  // Counter saturates at TIMEOUT_TICKS so the flag stays up until traffic resumes.
  always_comb begin
    idle_d    = idle_q;
    timeout_d = timeout_q;
    if (push | pop) begin
      idle_d    = '0;
      timeout_d = 1'b0;
    end else begin
      if (baud_tick & ~empty & (idle_q != TW'(TIMEOUT_TICKS))) idle_d = idle_q + TW'(1);
      if (idle_d == TW'(TIMEOUT_TICKS)) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_baud;
  assign unused_baud = &{1'b0, baud_tick, TIMEOUT_TICKS[0]};
  assign timeout     = 1'b0;
`endif

  assign rd_data = rd_data_q;
  assign count   = count_q;
  assign overrun = overrun_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo against a queue model
module tb_uart_rx_fifo;
  localparam int DL    = 4;
  localparam int DEPTH = 16;
  localparam int TT    = 40;
`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          RSTn;
  logic [7:0]    rx_data;
  logic          rx_done, baud_tick, rd_en, clr_ovr;
  logic [DL:0]   thresh;
  logic [7:0]    rd_data;
  logic          empty, full, overrun, timeout, irq;
  logic [DL:0]   count;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH_LOG2(DL), .TIMEOUT_TICKS(TT)) dut (
    .clk(clk), .RSTn(RSTn), .rx_data(rx_data), .rx_done(rx_done),
    .baud_tick(baud_tick), .rd_en(rd_en), .clr_ovr(clr_ovr), .thresh(thresh),
    .rd_data(rd_data), .empty(empty), .full(full), .count(count),
    .overrun(overrun), .timeout(timeout), .irq(irq)
  );

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tick();
  endtask

  // Reference model: a byte queue plus the flags, stepped once per clock.
  logic [7:0] mq[$];
  bit m_prev, m_inh, m_ovr, m_irq, m_to;
  bit m_pu, m_po, m_drop, m_irqn;
  int m_idle, m_n;

  always @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      mq.delete();
      m_prev = 1'b0; m_inh = 1'b1; m_ovr = 1'b0; m_irq = 1'b0; m_to = 1'b0; m_idle = 0;
    end else begin
      m_n    = mq.size();
      m_pu   = rx_done && !m_prev && !m_inh;
      m_po   = rd_en && (m_n != 0);
      m_drop = m_pu && (m_n == DEPTH) && !m_po;
      m_irqn = ((thresh != 0) && (m_n >= int'(thresh))) || m_ovr || m_to;
      if (m_po) void'(mq.pop_front());
      if (m_pu && !m_drop) mq.push_back(rx_data);
      m_ovr = m_drop || (m_ovr && !clr_ovr);
      if (TO_EN) begin
        if (m_pu || m_po) begin
          m_idle = 0;
          m_to   = 1'b0;
        end else if (baud_tick && (m_n != 0) && (m_idle < TT)) begin
          m_idle++;
          if (m_idle == TT) m_to = 1'b1;
        end
      end
      m_prev = rx_done;
      m_inh  = 1'b0;
      m_irq  = m_irqn;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("count", count, mq.size());
      check("empty", empty, mq.size() == 0);
      check("full", full, mq.size() == DEPTH);
      check("overrun", overrun, m_ovr);
      check("irq", irq, m_irq);
      check("timeout", timeout, m_to);
      if (mq.size() != 0) check("rd_data", rd_data, mq[0]);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RSTn = 1'b0; rx_data = 8'h00; rx_done = 1'b0; baud_tick = 1'b0;
    rd_en = 1'b0; clr_ovr = 1'b0; thresh = '0;
    tick();
    chk_en = 1'b1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_overrun", overrun, 0);
    check("rst_irq", irq, 0);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_timeout", timeout, 0);
    RSTn = 1'b1;
    tick();

    // Long strobe yields exactly one push
    rx_data = 8'hA5; rx_done = 1'b1;
    tick();
    check("single_lat_count", count, 1);
    tick(); tick();
    rx_done = 1'b0;
    tick();
    check("single_count", count, 1);
    check("single_data", rd_data, 8'hA5);
    check("single_empty", empty, 0);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("single_pop_empty", empty, 1);
    check("single_pop_count", count, 0);

    // Fill, overrun, drain in order, clear
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    check("fill_full", full, 1);
    check("fill_count", count, 16);
    push_byte(8'hFF);
    check("ovr_set", overrun, 1);
    check("ovr_irq", irq, 1);
    check("ovr_count", count, 16);
    for (int i = 0; i < 16; i++) begin
      check("pop_order", rd_data, 8'(i));
      rd_en = 1'b1; tick(); rd_en = 1'b0;
    end
    check("drain_empty", empty, 1);
    clr_ovr = 1'b1; tick(); clr_ovr = 1'b0; tick();
    check("clr_ovr", overrun, 0);
    check("clr_irq", irq, 0);

    // Push + pop while full
    for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i));
    rx_data = 8'hEE; rx_done = 1'b1; rd_en = 1'b1;
    tick();
    rx_done = 1'b0; rd_en = 1'b0;
    tick();
    check("pp_full_count", count, 16);
    check("pp_full_ovr", overrun, 0);
    check("pp_full_head", rd_data, 8'h11);
    for (int i = 0; i < 16; i++) begin
      check("pp_order", rd_data, (i < 15) ? 32'(8'h11 + i) : 32'hEE);
      rd_en = 1'b1; tick(); rd_en = 1'b0;
    end

    // Threshold interrupt
    thresh = 5'd4;
    for (int i = 0; i < 3; i++) push_byte(8'(8'h40 + i));
    check("thr_below", irq, 0);
    rx_data = 8'h43; rx_done = 1'b1;
    tick();
    check("thr_count4", count, 4);
    check("thr_irq_lag", irq, 0);
    rx_done = 1'b0;
    tick();
    check("thr_irq", irq, 1);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("thr_pop_lag", irq, 1);
    tick();
    check("thr_pop_irq", irq, 0);
    thresh = '0;
    for (int i = 0; i < 13; i++) push_byte(8'(8'h50 + i));
    check("thr0_full", full, 1);
    check("thr0_irq", irq, 0);
    thresh = 5'd17; tick(); tick();
    check("thr17_irq", irq, 0);
    thresh = 5'd16; tick(); tick();
    check("thr16_irq", irq, 1);
    thresh = '0;
    rd_en = 1'b1; repeat (16) tick(); rd_en = 1'b0;
    tick();

    // Reset with rx_done held high
    for (int i = 0; i < 5; i++) push_byte(8'(8'h60 + i));
    rx_data = 8'h77; rx_done = 1'b1;
    tick();
    RSTn = 1'b0; tick(); tick();
    check("rst_mid_count", count, 0);
    check("rst_mid_empty", empty, 1);
    check("rst_mid_irq", irq, 0);
    RSTn = 1'b1; tick(); tick(); tick();
    check("rst_nopush_count", count, 0);
    check("rst_nopush_empty", empty, 1);
    rx_done = 1'b0; tick();
    push_byte(8'h5A);
    check("rst_after_data", rd_data, 8'h5A);
    check("rst_after_count", count, 1);
    rd_en = 1'b1; tick(); rd_en = 1'b0;

    // Idle timeout
    push_byte(8'h3C);
    for (int i = 0; i < TT; i++) begin
      baud_tick = 1'b1; tick(); baud_tick = 1'b0; tick();
    end
    check("to_flag", timeout, TO_EN);
    check("to_irq", irq, TO_EN);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("to_clear", timeout, 0);
    tick();

    // Randomized traffic
    for (int ph = 0; ph < 40; ph++) begin
      int rd_prob;
      rd_prob = $urandom_range(0, 100);
      thresh  = 5'($urandom_range(0, 20));
      for (int c = 0; c < 100; c++) begin
        if (!rx_done) rx_data = 8'($urandom);
        rx_done   = ($urandom_range(0, 99) < 40);
        rd_en     = ($urandom_range(0, 99) < rd_prob);
        clr_ovr   = ($urandom_range(0, 31) == 0);
        baud_tick = ($urandom_range(0, 3) == 0);
        RSTn      = ($urandom_range(0, 499) != 0);
        tick();
      end
    end

    RSTn = 1'b1; rx_done = 1'b0; rd_en = 1'b0; clr_ovr = 1'b0; baud_tick = 1'b0;
    tick(); tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer directly downstream of the UART receiver. It captures each completed byte on the rising edge of the receiver's byte-done strobe and stores it in a show-ahead FIFO. Software or the bus-slave wrapper drains the FIFO through a simple pop interface. The block also raises a level interrupt on a fill threshold or an overrun.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (depth = 16); legal range 1..8
TIMEOUT_TICKS, 40, baud ticks of inactivity before the timeout flag sets (used only with the optional feature)

Ports:
clk  input  1  system clock
RSTn  input  1  asynchronous active-low reset
rx_data  input  8  received byte from the UART receiver; stable while rx_done is high
rx_done  input  1  byte-complete level from the receiver; may stay high for 1..N cycles
baud_tick  input  1  one-cycle baud enable pulse (same tick that drives the receiver)
rd_en  input  1  pop request; one byte popped per cycle when not empty
clr_ovr  input  1  one-cycle clear of the sticky overrun flag
thresh  input  DEPTH_LOG2+1  interrupt fill threshold; 0 disables the threshold interrupt
rd_data  output  8  head-of-FIFO byte (show-ahead); valid when empty=0
empty  output  1  FIFO empty
full  output  1  FIFO full
count  output  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2
overrun  output  1  sticky: a byte was dropped because the FIFO was full
timeout  output  1  idle timeout flag (optional feature)
irq  output  1  registered level interrupt

Behaviour:
- Reset values (asynchronous, RSTn low): pointers 0, count 0, empty 1, full 0, overrun 0, timeout 0, irq 0, rd_data 8'h00, edge-detect register 0. Memory contents are not reset.
- Push detection:
  - rx_done_q is a registered copy of rx_done.
  - push = rx_done & ~rx_done_q, so exactly one push per byte regardless of strobe length.
  - rx_data is written in the push cycle.
- Push latency: the byte is visible on rd_data, with empty=0 and count updated, on the clock edge after the push cycle.
- Pop:
  - rd_en with empty=0 advances the read pointer and decrements count.
  - rd_data shows the next entry after that edge.
  - rd_en with empty=1 is ignored; there is no underflow flag.
- rd_data is registered: it is loaded from memory at the new head whenever the pointers change.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. count is maintained as an explicit register: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous events:
  - Push + pop while empty: push accepted, pop ignored, count becomes 1.
  - Push + pop while full: both accepted, count stays at depth, no overrun.
  - Push while full without pop: byte dropped, memory and pointers unchanged, overrun set on the next edge.
  - clr_ovr in the same cycle as a new overrun: set wins, overrun stays 1.
- full = (count == depth); empty = (count == 0). Both are derived from the registered count.
- irq is registered one cycle after its conditions: irq <= ((thresh != 0) & (count >= thresh)) | overrun | timeout.
- thresh larger than depth never fires the threshold term.
- Reset asserted mid-byte or mid-burst discards all contents. After reset release, a rx_done already high produces no push until it falls and rises again, because rx_done_q resets to 0 but the push is qualified by the first post-reset sample: push is blocked while a one-cycle post-reset inhibit flop is set.

Optional Feature:
Macro: UART_RX_FIFO_TIMEOUT_EN.
- Defined:
  - An idle counter (width sized for TIMEOUT_TICKS) clears on push or pop and increments on baud_tick while empty=0.
  - When it reaches TIMEOUT_TICKS, timeout sets and the counter holds.
  - timeout clears on the next push, pop or reset.
  - timeout contributes to irq.
- Not defined: the counter is absent, timeout is tied 0, and baud_tick is unused.

Test Plan:
- Single byte: rx_done high 3 cycles with rx_data=8'hA5 -> exactly one push; next edge count=1, empty=0, rd_data=8'hA5. Pop -> empty=1, count=0.
- Fill and overrun (DEPTH_LOG2=4): push 16 bytes 8'h00..8'h0F -> full=1, count=16. 17th byte 8'hFF -> dropped, overrun=1, irq=1 next cycle. Pops return 8'h00..8'h0F in order. clr_ovr -> overrun=0.
- Simultaneous push+pop when full -> count stays 16, no overrun; the new byte emerges last after wrap-around.
- Threshold: thresh=4, push 3 bytes -> irq=0; 4th push -> irq=1 one cycle after count=4. Pop one -> irq=0. thresh=0 -> irq stays 0 at any count.
- Reset mid-operation: 5 bytes queued, RSTn pulsed low with rx_done held high -> count=0, empty=1, irq=0, and no spurious push after release.
- With UART_RX_FIFO_TIMEOUT_EN, TIMEOUT_TICKS=40: one byte queued, 40 baud_ticks without pops -> timeout=1, irq=1. Pop -> timeout=0. With the macro undefined, timeout stays 0.
